regfile_dump: RTL and testbench
===============================

# regfile_dump

Snapshot-and-stream engine for the register file. On a start pulse it captures the complete `register_array` into a shadow copy, then emits one register per valid/ready beat with its index, so a debug host or bench can read architectural state out word by word. It sits beside the register file, in parallel with the combinational `ila_rm` checker. Where the checker compares expected values against the file in one cycle, this block reads the file out over time. It also produces an XOR checksum of the streamed words.

## Interface
Parameters:
- NUM_REGS, 32, number of entries in `register_array`; must equal the `common` package definition.
- XLEN, 32, bits per register.
- SKIP_X0, 1, when 1 the stream starts at index 1 and x0 is never emitted.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low (asserted when rst == 0).
- start  in  1  request a dump; sampled only in IDLE.
- register_file  in  register_array  live register file contents.
- out_valid  out  1  out_index/out_data/out_last are valid.
- out_ready  in  1  consumer accepts the current beat.
- out_index  out  $clog2(NUM_REGS)  register number of the current beat.
- out_data  out  XLEN  snapshot value of that register.
- out_last  out  1  current beat is index NUM_REGS-1.
- busy  out  1  high in CAPTURE, SEND and DONE.
- done  out  1  one-cycle pulse after the last beat transfers.
- checksum  out  XLEN  XOR of all words transferred in the current or most recent dump.

## Operation
- The FSM has four states: IDLE, CAPTURE, SEND, DONE. Reset forces IDLE.
- IDLE:
  - busy=0, out_valid=0.
  - start=1 at an edge moves the FSM to CAPTURE.
- CAPTURE (exactly one cycle):
  - At the exiting edge, shadow[i] <= register_file[i] for all i.
  - idx <= SKIP_X0 ? 1 : 0.
  - checksum <= 0.
  - The FSM then moves to SEND.
- SEND:
  - out_valid=1, out_index=idx, out_data=shadow[idx], out_last=(idx==NUM_REGS-1).
  - A transfer happens at an edge where out_valid & out_ready: checksum <= checksum ^ out_data.
  - After a transfer, if out_last the FSM moves to DONE; otherwise idx <= idx+1.
  - When out_ready=0, all out_* signals are held stable and idx does not advance. out_valid never drops until a transfer occurs.
- DONE (one cycle):
  - done=1, out_valid=0.
  - The FSM then moves to IDLE.
- The streamed values are taken only from the shadow copy. Changes on register_file after CAPTURE do not affect the stream.
- start while busy=1 is ignored; it is not queued.
- checksum holds its final value from DONE until the next CAPTURE clears it.
- out_index and out_data are driven from registered idx/shadow only; there is no combinational path from register_file to any output.

## Timing
- Reset values: out_valid=0, out_index=0, out_data=0, out_last=0, busy=0, done=0, checksum=0, shadow all-zero, state IDLE.
- Reset assertion takes effect immediately, mid-dump included. No beat completes after reset; the next dump needs a fresh start.
- Latency: with start high at edge E0, busy rises after E0 and the snapshot is taken at E1. out_valid is high from after E1.
- With out_ready held 1, one beat transfers per cycle. The burst is NUM_REGS-SKIP_X0 beats: 31 at the defaults.
- done is high in the cycle after the last transfer edge. busy falls together with done, i.e. after the DONE cycle ends.
- Minimum start-to-done: 2 + (NUM_REGS-SKIP_X0) cycles, which is 33 at the defaults.
- Back-to-back dumps: a start asserted during the DONE cycle is ignored. The earliest accepted start is in the first IDLE cycle.
- Boundary cases:
  - idx never wraps; the last index is NUM_REGS-1.
  - With NUM_REGS=1 and SKIP_X0=0 the burst is a single beat with out_last=1.

## Test plan
- Reset + idle: hold rst=0, then release with start=0 for 10 cycles -> all outputs stay 0 and busy=0.
- Full dump, defaults, out_ready=1: load register_file[i]=i*0x11111111, pulse start -> 31 beats, index 1..31, data i*0x11111111. out_last is set only on index 31. done fires 33 cycles after start. checksum equals the XOR of those 31 values.
- Backpressure: toggle out_ready 1,0,0,1 repeatedly -> out_index and out_data stay stable while out_ready=0. No beat is duplicated or skipped, and the checksum is unchanged versus the previous scenario.
- Snapshot isolation: after CAPTURE, overwrite register_file with 0xDEADBEEF every cycle -> the streamed data still matches the pre-start values.
- Restart rules: pulse start during SEND and again in the DONE cycle -> both ignored and no second dump runs. A start in the next IDLE cycle begins a new dump with checksum cleared to 0.
- Reset mid-dump: assert rst=0 at beat index 10 -> out_valid, busy and checksum go to 0 at once and the FSM is IDLE. After release, a start yields a complete dump beginning at index 1.

Source files
------------

// File: rtl/regfile_dump.sv
// regfile_dump: snapshot the register file on a start pulse and stream it out one
// register per valid/ready beat, with index and a running XOR checksum.
module regfile_dump #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned XLEN     = 32,
  parameter bit          SKIP_X0  = 1'b1,
  // Keep the index at least one bit wide so a single-entry file still has a port.
  localparam int unsigned IdxW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [XLEN-1:0]     register_file [NUM_REGS],
  output logic                out_valid,
  input  logic                out_ready,
  output logic [IdxW-1:0]     out_index,
  output logic [XLEN-1:0]     out_data,
  output logic                out_last,
  output logic                busy,
  output logic                done,
  output logic [XLEN-1:0]     checksum
);

  typedef enum logic [1:0] {StIdle, StCapture, StSend, StDone} state_e;

  localparam logic [IdxW-1:0] FirstIdx = SKIP_X0 ? IdxW'(1) : '0;
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(NUM_REGS - 1);

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [XLEN-1:0] checksum_q, checksum_d;
  logic [XLEN-1:0] shadow_q [NUM_REGS];
  logic            send_active;
  logic            is_last;

  assign send_active = (state_q == StSend);
  assign is_last     = (idx_q == LastIdx);

  // Next-state, index/checksum update and all outputs.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    checksum_d = checksum_q;

    // Outputs come only from registered state; gated to zero outside SEND.
    out_valid = send_active;
    out_last  = send_active && is_last;
    out_index = send_active ? idx_q : '0;
    out_data  = send_active ? shadow_q[idx_q] : '0;
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
    checksum  = checksum_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StCapture;
        end
      end
      StCapture: begin
        idx_d      = FirstIdx;
        checksum_d = '0;
        state_d    = StSend;
      end
      StSend: begin
        if (out_ready) begin
          checksum_d = checksum_q ^ shadow_q[idx_q];
          if (is_last) begin
            state_d = StDone;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM state, stream index and checksum registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      checksum_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      checksum_q <= checksum_d;
    end
  end

  // Shadow copy: whole file captured at the edge leaving CAPTURE, held otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        shadow_q[i] <= '0;
      end
    end else if (state_q == StCapture) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        shadow_q[i] <= register_file[i];
      end
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump at default parameters.
module tb_regfile_dump;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] rf [32];
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_index;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;
  logic [31:0] checksum;

  int          n_vec = 0;
  int          n_err = 0;
  int          edges = 0;
  logic [31:0] exp_data [32];
  logic [31:0] ck_ref;
  int          t0;

  regfile_dump dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .register_file(rf),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_index    (out_index),
    .out_data     (out_data),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done),
    .checksum     (checksum)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    edges++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expects to be in the first SEND cycle; streams beats 1..31 with ready high and
  // returns in the DONE cycle. Optionally pulses start during beat pulse_at.
  task automatic drain(input string tag, input int pulse_at);
    logic [31:0] x;
    x = '0;
    out_ready = 1'b1;
    for (int i = 1; i < 32; i++) begin
      start = (i == pulse_at);
      chk({tag, " valid"}, 32'(out_valid), 32'd1);
      chk({tag, " index"}, 32'(out_index), i);
      chk({tag, " data"},  out_data, exp_data[i]);
      chk({tag, " last"},  32'(out_last), 32'(i == 31));
      x ^= exp_data[i];
      step();
    end
    start = 1'b0;
    chk({tag, " done"},     32'(done), 32'd1);
    chk({tag, " busyDone"}, 32'(busy), 32'd1);
    chk({tag, " validDone"}, 32'(out_valid), 32'd0);
    chk({tag, " checksum"}, checksum, x);
  endtask

  task automatic start_dump();
    start = 1'b1;
    step();
    chk("capture busy", 32'(busy), 32'd1);
    chk("capture valid", 32'(out_valid), 32'd0);
    start = 1'b0;
    step();
  endtask

  initial begin
    int c;
    int e;
    logic [3:0] pat;

    rst = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h1111_1111;
    #1;
    // Reset state
    chk("rst valid", 32'(out_valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst checksum", checksum, 32'd0);
    step();
    step();
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("idle outs", {out_valid, busy, done, out_last, out_index, 22'd0},  32'd0);
      chk("idle data", out_data | checksum, 32'd0);
    end

    // Full dump with ready held high
    for (int i = 0; i < 32; i++) exp_data[i] = 32'(i) * 32'h1111_1111;
    ck_ref = '0;
    for (int i = 1; i < 32; i++) ck_ref ^= exp_data[i];
    t0 = edges;
    start_dump();
    chk("first index", 32'(out_index), 32'd1);
    drain("full", 0);
    chk("start-to-done", edges - t0, 33);
    chk("full ck ref", checksum, ck_ref);
    step();
    chk("after done busy", 32'(busy), 32'd0);
    chk("after done done", 32'(done), 32'd0);
    chk("checksum held", checksum, ck_ref);
    step();
    chk("no second dump", 32'(busy), 32'd0);

    // Backpressure: ready pattern 1,0,0,1 repeated
    pat = 4'b1001;
    start_dump();
    e = 1;
    c = 0;
    while (e <= 31 && c < 400) begin
      out_ready = pat[3 - (c % 4)];
      chk("bp valid", 32'(out_valid), 32'd1);
      chk("bp index", 32'(out_index), e);
      chk("bp data", out_data, exp_data[e]);
      step();
      if (out_ready) e++;
      c++;
    end
    chk("bp bound", 32'(e), 32'd32);
    chk("bp done", 32'(done), 32'd1);
    chk("bp checksum", checksum, ck_ref);
    out_ready = 1'b1;
    step();

    // Snapshot isolation
    for (int i = 0; i < 32; i++) begin
      rf[i] = 32'hC0DE_0000 + 32'(i * 7);
      exp_data[i] = rf[i];
    end
    start_dump();
    for (int i = 0; i < 32; i++) rf[i] = 32'hDEAD_BEEF;
    drain("snap", 0);
    step();

    // Restart rules: start in SEND and in DONE are ignored
    for (int i = 0; i < 32; i++) begin
      rf[i] = 32'h0F0F_0000 ^ (32'(i) << 3);
      exp_data[i] = rf[i];
    end
    start_dump();
    drain("restart", 5);
    ck_ref = checksum;
    start = 1'b1;
    step();
    chk("start in done ignored", 32'(busy), 32'd0);
    chk("idle after done valid", 32'(out_valid), 32'd0);
    step();
    chk("idle start accepted", 32'(busy), 32'd1);
    chk("capture keeps ck", checksum, ck_ref);
    start = 1'b0;
    step();
    chk("restart ck cleared", checksum, 32'd0);
    drain("restart2", 0);
    step();

    // Reset in the middle of a dump
    for (int i = 0; i < 32; i++) exp_data[i] = rf[i];
    start_dump();
    out_ready = 1'b1;
    for (int i = 1; i < 10; i++) step();
    chk("pre-reset index", 32'(out_index), 32'd10);
    rst = 1'b0;
    #1;
    chk("mid rst valid", 32'(out_valid), 32'd0);
    chk("mid rst busy", 32'(busy), 32'd0);
    chk("mid rst checksum", checksum, 32'd0);
    chk("mid rst index", 32'(out_index), 32'd0);
    step();
    step();
    rst = 1'b1;
    step();
    chk("post rst idle", 32'(busy) | 32'(out_valid), 32'd0);
    start_dump();
    drain("post rst", 0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
